// File: rtl/dac_playback_tx_if.sv
// Upstream sample stream into the DAC playback block.
// One 8-bit offset-binary sample moves per cycle where s_valid && s_ready.
interface dac_playback_tx_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    // Sample producer side
    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    // Playback block side
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/dac_playback_tx.sv
// DAC playback transmitter.
// Buffers upstream samples in a DEPTH-entry FIFO and plays them out to an
// 8-bit parallel DAC at one sample every DIV clk cycles. daclk rises half a
// sample period after da changes, so da is settled when the DAC latches it.
// Playback starts only once PRIME_LEVEL samples are buffered; running dry
// raises a sticky underrun flag and re-primes before playback resumes.
module dac_playback_tx #(
    parameter int DEPTH       = 16,  // FIFO depth, power of two, >= 4
    parameter int DIV         = 4,   // clk cycles per DAC sample, even, >= 2
    parameter int PRIME_LEVEL = 4    // fill needed before playback, 1..DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear_underrun,
    dac_playback_tx_if.slave       s_if,
    output logic [7:0]             da,
    output logic                   daclk,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int AW = $clog2(DEPTH);      // FIFO pointer width
    localparam int LW = AW + 1;             // occupancy width, holds DEPTH
    localparam int PW = $clog2(DIV);        // phase counter width

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF   = PW'(DIV / 2);

    // Mid-scale code of an offset-binary DAC: analog zero.
    localparam logic [7:0] MID_CODE = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,   // stopped, FIFO may be preloaded
        ST_PRIME,  // waiting for enough buffered samples
        ST_RUN     // playing one sample per DIV cycles
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [PW-1:0]   ph_q;
    logic [7:0]      da_q;
    logic            daclk_q;
    logic            underrun_q;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q,  level_d;
    logic [7:0]      mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic            s_ready;
    logic            fifo_empty;
    logic            tick;
    logic            flush;
    logic            push;
    logic            pop;
    logic            underrun_set;
    logic [PW-1:0]   ph_inc;
    logic [7:0]      head;

    // Ready depends only on the registered occupancy, never on s_valid.
    assign s_ready      = (level_q != FULL_LVL);
    assign fifo_empty   = (level_q == '0);

    // A sample period starts whenever the phase counter is at zero in RUN.
    assign tick         = (state_q == ST_RUN) && (ph_q == '0);

    // Leaving PRIME or RUN for IDLE empties the FIFO; dropping enable
    // has priority over everything else happening on that edge.
    assign flush        = (state_q != ST_IDLE) && !enable;

    assign push         = s_if.s_valid && s_ready && !flush;
    assign pop          = tick && enable && !fifo_empty;
    assign underrun_set = tick && enable && fifo_empty;

    assign ph_inc       = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    assign head         = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO pointer and occupancy next-state
    // ------------------------------------------------------------------
    // Next pointers and level from push/pop/flush.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;  // idle, or push and pop cancel
            endcase
        end
    end

    // Register FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only read after it was written, and leaving it out keeps it in RAM.
        if (push) begin
            mem_q[wr_ptr_q] <= s_if.s_data;
        end
    end

    // ------------------------------------------------------------------
    // Playback state machine with registered DAC outputs
    // ------------------------------------------------------------------
    // Sequence IDLE/PRIME/RUN, advance the phase, drive da/daclk/underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            da_q       <= MID_CODE;
            daclk_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            // daclk is low outside the second half of a RUN sample period.
            daclk_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    ph_q <= '0;
                    da_q <= MID_CODE;
                    if (enable) begin
                        state_q <= ST_PRIME;
                    end
                end

                ST_PRIME: begin
                    ph_q <= '0;
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        da_q    <= MID_CODE;
                    end else if (level_q >= PRIME_LVL) begin
                        // The first tick lands on the very next edge.
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        ph_q    <= '0;
                        da_q    <= MID_CODE;
                    end else if (underrun_set) begin
                        // Nothing to play: park at mid-scale and re-prime.
                        state_q <= ST_PRIME;
                        ph_q    <= '0;
                        da_q    <= MID_CODE;
                    end else begin
                        ph_q    <= ph_inc;
                        daclk_q <= (ph_inc >= PH_HALF);
                        if (pop) begin
                            da_q <= head;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    ph_q    <= '0;
                    da_q    <= MID_CODE;
                end
            endcase

            // Sticky flag; a new underrun wins over a simultaneous clear.
            underrun_q <= underrun_set | (underrun_q & ~clear_underrun);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_if.s_ready = s_ready;
    assign da           = da_q;
    assign daclk        = daclk_q;
    assign underrun     = underrun_q;
    assign level        = level_q;

endmodule

// File: tb/tb_dac_playback_tx.sv
// Self-checking bench for dac_playback_tx (DEPTH=16, DIV=4, PRIME_LEVEL=4).
// A table of hand-derived vectors covers preload/start/underrun, directed
// sequences cover full, push+pop, disable and reset corners, and a random
// run is compared every cycle against a queue-based reference model.
module tb_dac_playback_tx;

    localparam int DEPTH       = 16;
    localparam int DIV         = 4;
    localparam int PRIME_LEVEL = 4;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clear_underrun = 1'b0;
    logic [7:0]    da;
    logic          daclk;
    logic          underrun;
    logic [LW-1:0] level;

    dac_playback_tx_if bus ();

    dac_playback_tx #(
        .DEPTH       (DEPTH),
        .DIV         (DIV),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .clear_underrun (clear_underrun),
        .s_if           (bus),
        .da             (da),
        .daclk          (daclk),
        .underrun       (underrun),
        .level          (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: playback behaviour in terms of a sample queue
    // ------------------------------------------------------------------
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    int          m_state = M_IDLE;
    int          m_ph    = 0;
    byte unsigned m_q[$];
    logic [7:0]  m_da    = 8'h80;
    logic        m_ur    = 1'b0;

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input logic rst, input logic en, input logic v,
                              input logic [7:0] d, input logic clr);
        int  n;
        bit  accept;
        bit  set_ur;
        if (rst) begin
            m_state = M_IDLE;
            m_ph    = 0;
            m_q.delete();
            m_da    = 8'h80;
            m_ur    = 1'b0;
        end else begin
            n      = m_q.size();
            accept = v && (n != DEPTH);
            set_ur = 1'b0;
            case (m_state)
                M_IDLE: begin
                    if (accept) m_q.push_back(d);
                    m_da = 8'h80;
                    m_ph = 0;
                    if (en) m_state = M_PRIME;
                end
                M_PRIME: begin
                    if (!en) begin
                        m_state = M_IDLE;
                        m_q.delete();
                        m_da = 8'h80;
                    end else begin
                        if (accept) m_q.push_back(d);
                        if (n >= PRIME_LEVEL) m_state = M_RUN;
                    end
                end
                default: begin
                    if (!en) begin
                        m_state = M_IDLE;
                        m_q.delete();
                        m_da = 8'h80;
                        m_ph = 0;
                    end else begin
                        if (m_ph == 0) begin
                            if (n > 0) begin
                                m_da = m_q.pop_front();
                            end else begin
                                m_da    = 8'h80;
                                set_ur  = 1'b1;
                                m_state = M_PRIME;
                            end
                        end
                        if (accept) m_q.push_back(d);
                        m_ph = (m_state == M_RUN) ? (m_ph + 1) % DIV : 0;
                    end
                end
            endcase
            m_ur = set_ur ? 1'b1 : (clr ? 1'b0 : m_ur);
        end
    endtask

    // Apply one cycle of inputs, clock it, update the model, settle.
    task automatic step(input logic rst, input logic en, input logic v,
                        input logic [7:0] d, input logic clr);
        @(negedge clk);
        reset          = rst;
        enable         = en;
        bus.s_valid    = v;
        bus.s_data     = d;
        clear_underrun = clr;
        @(posedge clk);
        model_edge(rst, en, v, d, clr);
        #1;
    endtask

    task automatic compare_model();
        check("level",    level,       m_q.size());
        check("da",       da,          m_da);
        check("daclk",    daclk,       (m_state == M_RUN) && (m_ph >= DIV / 2));
        check("underrun", underrun,    m_ur);
        check("s_ready",  bus.s_ready, m_q.size() != DEPTH);
    endtask

    // ------------------------------------------------------------------
    // Hand-derived vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       clr;
        int         lvl;
        logic [7:0] e_da;
        logic       e_dc;
        logic       e_ur;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic v,
                                input logic [7:0] d, input logic clr, input int lvl,
                                input logic [7:0] e_da, input logic e_dc,
                                input logic e_ur, input logic e_rdy);
        vec_t r;
        r.rst = rst; r.en = en; r.v = v; r.d = d; r.clr = clr;
        r.lvl = lvl; r.e_da = e_da; r.e_dc = e_dc; r.e_ur = e_ur; r.e_rdy = e_rdy;
        return r;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        byte unsigned got[$];
        logic         prev_dc;
        int           ticks;
        bit           reached;
        logic         v;
        logic [7:0]   dval;
        bit           en_r;
        int           vprob;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        //              rst en v  d      clr lvl da     dc ur rdy
        tbl.push_back(mk(1, 0, 0, 8'h00, 0,  0, 8'h80, 0, 0, 1)); // reset
        tbl.push_back(mk(0, 0, 1, 8'h01, 0,  1, 8'h80, 0, 0, 1)); // preload
        tbl.push_back(mk(0, 0, 1, 8'h02, 0,  2, 8'h80, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h03, 0,  3, 8'h80, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h04, 0,  4, 8'h80, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  4, 8'h80, 0, 0, 1)); // -> PRIME
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  4, 8'h80, 0, 0, 1)); // -> RUN
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h01, 0, 0, 1)); // tick
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h01, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h01, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h01, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  2, 8'h02, 0, 0, 1)); // tick
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  2, 8'h02, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  2, 8'h02, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  2, 8'h02, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  1, 8'h03, 0, 0, 1)); // tick
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  1, 8'h03, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  1, 8'h03, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  1, 8'h03, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  0, 8'h04, 0, 0, 1)); // tick
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  0, 8'h04, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  0, 8'h04, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  0, 8'h04, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1,  0, 8'h80, 0, 1, 1)); // underrun, set beats clear
        tbl.push_back(mk(0, 1, 1, 8'h10, 0,  1, 8'h80, 0, 1, 1)); // refill in PRIME
        tbl.push_back(mk(0, 1, 1, 8'h11, 0,  2, 8'h80, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 8'h12, 0,  3, 8'h80, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 8'h13, 0,  4, 8'h80, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  4, 8'h80, 0, 1, 1)); // -> RUN
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h10, 0, 1, 1)); // resumes
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h10, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1,  3, 8'h10, 1, 0, 1)); // clear
        tbl.push_back(mk(0, 1, 0, 8'h00, 0,  3, 8'h10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0,  0, 8'h80, 0, 0, 1)); // disable flushes
        tbl.push_back(mk(0, 0, 1, 8'h55, 0,  1, 8'h80, 0, 0, 1)); // preload again
        tbl.push_back(mk(1, 1, 1, 8'h66, 1,  0, 8'h80, 0, 0, 1)); // reset wins

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].clr);
            check($sformatf("tbl%0d_level", i),    level,       tbl[i].lvl);
            check($sformatf("tbl%0d_da", i),       da,          tbl[i].e_da);
            check($sformatf("tbl%0d_daclk", i),    daclk,       tbl[i].e_dc);
            check($sformatf("tbl%0d_underrun", i), underrun,    tbl[i].e_ur);
            check($sformatf("tbl%0d_s_ready", i),  bus.s_ready, tbl[i].e_rdy);
        end

        // -------- Full FIFO: 20 cycles of s_valid in IDLE, then play ----
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 8'(i), 0);
            compare_model();
        end
        check("full_level", level, DEPTH);
        check("full_s_ready", bus.s_ready, 0);
        got.delete();
        prev_dc = 1'b0;
        for (int c = 0; c < 120 && got.size() < DEPTH; c++) begin
            step(0, 1, 0, 8'h00, 0);
            compare_model();
            if (daclk && !prev_dc) got.push_back(da);
            prev_dc = daclk;
        end
        check("full_played", got.size(), DEPTH);
        foreach (got[k]) check($sformatf("full_order%0d", k), got[k], k);

        // -------- Push and pop on the same tick at level 16 --------------
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(8'h20 + i), 0);
        dval = 8'h30;
        for (int c = 0; c < 40; c++) begin
            step(0, 1, 1, dval, 0);
            if (bus.s_ready === 1'b1) dval++;
            compare_model();
        end

        // -------- Push and pop on the same tick at level 5 ---------------
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h40 + i), 0);
        dval  = 8'h45;
        ticks = 0;
        for (int c = 0; c < 60 && ticks < 4; c++) begin
            v = (m_state == M_RUN) && (m_ph == 0);
            step(0, 1, v, dval, 0);
            compare_model();
            if (v) begin
                check("pp_level5", level, 5);
                dval++;
                ticks++;
            end
        end
        check("pp_ticks", ticks, 4);

        // -------- Disable mid-RUN with level 7 ---------------------------
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(8'h60 + i), 0);
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_state == M_RUN && m_q.size() == 7 && m_ph == DIV - 1) begin
                reached = 1'b1;
                break;
            end
            step(0, 1, 0, 8'h00, 0);
            compare_model();
        end
        check("dis_reached", reached, 1);
        check("dis_pre_daclk", daclk, 1);
        step(0, 0, 0, 8'h00, 0);
        check("dis_level", level, 0);
        check("dis_da", da, 8'h80);
        check("dis_daclk", daclk, 0);

        // -------- Reset mid-RUN with level 9 and underrun set ------------
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h70 + i), 0);
        reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            step(0, 1, 0, 8'h00, 0);
            compare_model();
            reached = m_ur;
        end
        check("rst_underrun_seen", reached, 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 8'(8'h90 + i), 0);
            compare_model();
        end
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_state == M_RUN && m_q.size() == 9 && m_ph == 2) begin
                reached = 1'b1;
                break;
            end
            step(0, 1, 0, 8'h00, 0);
            compare_model();
        end
        check("rst_reached", reached, 1);
        check("rst_pre_underrun", underrun, 1);
        step(1, 1, 1, 8'hAA, 0);
        check("rst_level", level, 0);
        check("rst_da", da, 8'h80);
        check("rst_daclk", daclk, 0);
        check("rst_underrun", underrun, 0);
        check("rst_s_ready", bus.s_ready, 1);

        // -------- Randomised run against the model -----------------------
        step(1, 0, 0, 8'h00, 0);
        en_r  = 1'b1;
        vprob = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       vprob = 15;
                    1:       vprob = 25;
                    2:       vprob = 50;
                    default: vprob = 90;
                endcase
            end
            if ($urandom_range(0, 39) == 0) en_r = !en_r;
            step($urandom_range(0, 499) == 0, en_r,
                 $urandom_range(0, 99) < vprob, 8'($urandom),
                 $urandom_range(0, 15) == 0);
            compare_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_playback_tx.md
DAC_PLAYBACK_TX -- requirements
Module: dac_playback_tx

Parameters
REQ-001 The block SHALL have a parameter DEPTH, default 16, meaning the sample FIFO depth; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have a parameter DIV, default 4, meaning clk cycles per DAC sample; it SHALL be even and at least 2.
REQ-003 The block SHALL have a parameter PRIME_LEVEL, default 4, meaning the FIFO fill required before playback starts; it SHALL be between 1 and DEPTH inclusive.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run request for playback.
REQ-007 The block SHALL have port s_valid, input, 1 bit: the upstream sample is valid.
REQ-008 The block SHALL have port s_data, input, 8 bits: the upstream sample, unsigned offset-binary.
REQ-009 The block SHALL have port s_ready, output, 1 bit: the FIFO can accept a sample.
REQ-010 The block SHALL have port clear_underrun, input, 1 bit: clears the underrun flag.
REQ-011 The block SHALL have port da, output, 8 bits: the DAC data bus.
REQ-012 The block SHALL have port daclk, output, 1 bit: the DAC latch clock; the DAC captures da on the rising edge of daclk.
REQ-013 The block SHALL have port underrun, output, 1 bit: sticky flag indicating the FIFO was empty at a sample tick.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-015 s_ready SHALL equal (level != DEPTH), driven from registered state only.
REQ-016 A sample SHALL be pushed on a cycle where s_valid && s_ready; the sample is written at the tail and level increments next cycle.
REQ-017 Data SHALL be pushed and popped in FIFO order; a push and a pop in the same cycle SHALL leave level unchanged and lose no data.
REQ-018 The block SHALL use a phase counter ph that counts 0..DIV-1 and wraps, running only in RUN; a "tick" is the condition ph==0 in RUN.
REQ-019 daclk SHALL be registered, equal to 1 when ph >= DIV/2 in RUN, and 0 otherwise; da is therefore stable DIV/2 cycles before each daclk rise.
REQ-020 The state machine SHALL have the states IDLE, PRIME and RUN.
REQ-021 In IDLE: pushes are accepted (preload); ph=0; da=8'h80; go to PRIME when enable=1.
REQ-022 In PRIME: ph held at 0; da held; go to RUN when level >= PRIME_LEVEL; go to IDLE when enable=0.
REQ-023 In RUN at a tick with level > 0: pop the head and load da with the head value on the same edge; latency from the PRIME-to-RUN transition to the first da update SHALL be 1 cycle.
REQ-024 In RUN at a tick with level == 0: da SHALL be loaded with 8'h80, underrun SHALL be set, and the state SHALL go to PRIME with ph reset to 0.
REQ-025 In RUN: enable=0 SHALL cause a transition to IDLE on the next edge, regardless of ph.
REQ-026 Any transition into IDLE from PRIME or RUN SHALL flush the FIFO (level=0, pointers equal); a push in that same cycle is discarded.
REQ-027 underrun SHALL be cleared by clear_underrun=1; if a set condition and clear_underrun coincide, set SHALL win.
REQ-028 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-029 When reset=1 at a clk edge: state=IDLE, ph=0, level=0, both FIFO pointers=0, da=8'h80, daclk=0, underrun=0; reset SHALL override all other inputs, including mid-RUN.
REQ-030 s_ready SHALL be 1 in the cycle following reset release.

Verification (DEPTH=16, DIV=4, PRIME_LEVEL=4)
REQ-031 Preload and start: push 1,2,3,4 in IDLE, then raise enable -> RUN entered; da=1,2,3,4 at 4-cycle spacing; daclk high for 2 of every 4 cycles with its rise 2 cycles after each da change.
REQ-032 Underrun: play exactly 4 samples with no further pushes -> at the 5th tick da=8'h80, underrun=1, state=PRIME; push 4 more samples -> playback resumes; underrun stays 1 until clear_underrun is pulsed.
REQ-033 Full: hold s_valid=1 in IDLE for 20 cycles -> level=16, s_ready=0 from the 17th cycle on, 16 samples stored; entering RUN then outputs 0..15 in order.
REQ-034 Simultaneous push and pop: at a tick with level=16 and level=5 -> level is unchanged when s_ready permits the push, and the output order is preserved.
REQ-035 Disable mid-RUN: drop enable with level=7 -> next cycle state=IDLE, level=0, da=8'h80, daclk=0.
REQ-036 Reset mid-RUN with level=9 and underrun=1 -> all REQ-029 values hold on the next cycle.
